ahbl_apb3_bridge: RTL

AHBL_APB3_BRIDGE -- requirements
Module: ahbl_apb3_bridge

---
 rtl/ahbl_apb3_bridge_pkg.sv | 32 +++
 rtl/ahbl_apb3_bridge_if.sv | 40 ++++
 rtl/apb_slot_decode.sv | 18 +
 rtl/ahbl_apb3_bridge.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ahbl_apb3_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
package ahbl_apb3_bridge_pkg;

  localparam int SLOT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  // Keeps the low 'width' address bits; the rest read as zero on PADDR.
  function automatic logic [31:0] paddr_mask(int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
  endfunction

endpackage

// File: rtl/ahbl_apb3_bridge_if.sv
// AHB-Lite slave port plus APB3 master port of the bridge, one bundle.
interface ahbl_apb3_bridge_if #(
  parameter int NUM_SLOTS = 16
);
  logic                 HSEL;
  logic                 HWRITE;
  logic                 HREADYIN;
  logic [31:0]          HADDR;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic [31:0]          HWDATA;
  logic                 HREADYOUT;
  logic                 HRESP;
  logic [31:0]          HRDATA;

  logic [NUM_SLOTS-1:0] PSEL;
  logic [31:0]          PADDR;
  logic                 PWRITE;
  logic                 PENABLE;
  logic [31:0]          PWDATA;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  // Bridge view: AHB slave on one side, APB master on the other.
  modport slave (
    input  HSEL, HWRITE, HREADYIN, HADDR, HTRANS, HSIZE, HWDATA,
    output HREADYOUT, HRESP, HRDATA,
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // System view: AHB master plus the APB peripherals.
  modport master (
    output HSEL, HWRITE, HREADYIN, HADDR, HTRANS, HSIZE, HWDATA,
    input  HREADYOUT, HRESP, HRDATA,
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slot_decode.sv
// Slot index to one-hot PSEL vector, with a flag for out-of-range slots.
module apb_slot_decode
  import ahbl_apb3_bridge_pkg::*;
#(
  parameter int NUM_SLOTS = 16
) (
  input  logic [SLOT_W-1:0]    slot,
  output logic [NUM_SLOTS-1:0] sel,
  output logic                 in_range
);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_sel
    assign sel[i] = (slot == SLOT_W'(i));
  end

  assign in_range = (32'(slot) < 32'(NUM_SLOTS));

endmodule

// File: rtl/ahbl_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge; one APB transfer per AHB transfer.
module ahbl_apb3_bridge
  import ahbl_apb3_bridge_pkg::*;
#(
  parameter int NUM_SLOTS   = 16,
  parameter int SLOT_LSB    = 24,
  parameter int PADDR_WIDTH = 24,
  parameter int TIMEOUT     = 0
) (
  input logic               HCLK,
  input logic               HRESETN,
  ahbl_apb3_bridge_if.slave bus
);

  localparam logic [31:0] PADDR_MASK = paddr_mask(PADDR_WIDTH);
  localparam int          TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e                 state;
  logic [31:0]            addr_q;
  logic                   write_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [TO_W-1:0]        to_cnt;
  logic [NUM_SLOTS-1:0]   slot_sel;
  logic                   slot_ok;
  logic                   accept;
  logic                   to_expire;

  apb_slot_decode #(.NUM_SLOTS(NUM_SLOTS)) u_decode (
    .slot     (slot_q),
    .sel      (slot_sel),
    .in_range (slot_ok)
  );

  assign accept    = bus.HSEL && bus.HREADYIN && bus.HTRANS[1];
  assign to_expire = (TIMEOUT > 0) && (to_cnt == TO_W'(TIMEOUT - 1));

  // Transfer size and the SEQ/NONSEQ distinction have no effect on APB.
  logic unused_bits;
  assign unused_bits = ^{bus.HSIZE, bus.HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      slot_q        <= '0;
      to_cnt        <= '0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= HRESP_OKAY;
      bus.HRDATA    <= '0;
      bus.PSEL      <= '0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q        <= bus.HADDR;
            write_q       <= bus.HWRITE;
            slot_q        <= bus.HADDR[SLOT_LSB +: SLOT_W];
            bus.HREADYOUT <= 1'b0;
            state         <= ST_WDATA;
          end
        end

        ST_WDATA: begin
          bus.PWDATA <= bus.HWDATA;
          if (slot_ok) begin
            bus.PSEL   <= slot_sel;
            bus.PADDR  <= addr_q & PADDR_MASK;
            bus.PWRITE <= write_q;
            state      <= ST_SETUP;
          end else begin
            // Unmapped slot: no APB cycle, straight to the error response.
            bus.HRESP <= HRESP_ERROR;
            state     <= ST_ERR1;
          end
        end

        ST_SETUP: begin
          bus.PENABLE <= 1'b1;
          to_cnt      <= '0;
          state       <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (bus.PREADY) begin
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            to_cnt      <= '0;
            if (!bus.PSLVERR) begin
              if (!write_q) bus.HRDATA <= bus.PRDATA;
              bus.HREADYOUT <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              bus.HRESP <= HRESP_ERROR;
              state     <= ST_ERR1;
            end
          end else if (to_expire) begin
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            to_cnt      <= '0;
            bus.HRESP   <= HRESP_ERROR;
            state       <= ST_ERR1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_ERR1: begin
          bus.HREADYOUT <= 1'b1;
          state         <= ST_ERR2;
        end

        ST_ERR2: begin
          bus.HRESP <= HRESP_OKAY;
          state     <= ST_IDLE;
        end

        default: begin
          bus.HREADYOUT <= 1'b1;
          bus.HRESP     <= HRESP_OKAY;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
